// File: rtl/bht_predictor_pkg.sv
// Shared constants for the branch history table: geometry, counter
// encodings and the counter value used when a new entry is allocated.
package bht_predictor_pkg;

  localparam int BHT_INDEX_BITS = 3;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_cnt_e;

  localparam logic [1:0] BHT_INIT_CNT = BHT_WT;

endpackage

// File: rtl/bht_predictor_sat_counter2.sv
// Two-bit saturating up/down counter, purely combinational: returns the
// value the counter should take next given an increment or decrement.
module sat_counter2
  import bht_predictor_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [1:0] o_next
);

  // Simultaneous inc and dec cancel out and hold the current value.
  always_comb begin
    o_next = i_cnt;
    if (i_inc && !i_dec && (i_cnt != BHT_ST)) begin
      o_next = i_cnt + 2'd1;
    end else if (i_dec && !i_inc && (i_cnt != BHT_SNT)) begin
      o_next = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped branch history table: combinational IF-stage lookup,
// combinational EX-stage mispredict detection, registered table update.
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int         INDEX_BITS = BHT_INDEX_BITS,
  parameter int         TAG_BITS   = 30 - INDEX_BITS,
  parameter logic [1:0] INIT_CNT   = BHT_INIT_CNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc_if,
  output logic [31:0] o_pc_predict,
  output logic [1:0]  o_binary_predict,
  output logic        o_bht_hit,
  input  logic        i_resolve_valid,
  input  logic [31:0] i_resolve_pc,
  input  logic        i_resolve_taken,
  input  logic [31:0] i_resolve_target,
  input  logic [31:0] i_pc_predict_ex,
  output logic        o_predict_fail,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_branch_cnt,
  output logic [31:0] o_fail_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [1:0]          r_cnt    [ENTRIES];
  logic [31:0]         r_branch_cnt;
  logic [31:0]         r_fail_cnt;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0]   w_if_tag;
  logic                  w_if_hit;
  logic [INDEX_BITS-1:0] w_rs_idx;
  logic [TAG_BITS-1:0]   w_rs_tag;
  logic                  w_rs_hit;
  logic [31:0]           w_actual;
  logic                  w_fail;
  logic [1:0]            w_cnt_next;
  logic                  w_unused_bits;

  // Instructions are word aligned, so the byte-offset bits carry no information.
  assign w_unused_bits = ^{i_pc_if[1:0], i_resolve_pc[1:0]};

  assign w_if_idx = i_pc_if[INDEX_BITS+1:2];
  assign w_if_tag = i_pc_if[31:INDEX_BITS+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

  assign o_bht_hit        = w_if_hit;
  assign o_binary_predict = w_if_hit ? r_cnt[w_if_idx] : 2'b00;
  assign o_pc_predict     = (w_if_hit && r_cnt[w_if_idx][1]) ? r_target[w_if_idx]
                                                             : i_pc_if + 32'd4;

  assign w_actual       = i_resolve_taken ? i_resolve_target : i_resolve_pc + 32'd4;
  assign w_fail         = i_resolve_valid && (i_pc_predict_ex != w_actual);
  assign o_predict_fail = w_fail;
  assign o_redirect_pc  = i_resolve_valid ? w_actual : 32'd0;

  assign w_rs_idx = i_resolve_pc[INDEX_BITS+1:2];
  assign w_rs_tag = i_resolve_pc[31:INDEX_BITS+2];
  assign w_rs_hit = r_valid[w_rs_idx] && (r_tag[w_rs_idx] == w_rs_tag);

  sat_counter2 u_sat_counter2 (
    .i_cnt  (r_cnt[w_rs_idx]),
    .i_inc  (i_resolve_taken),
    .i_dec  (!i_resolve_taken),
    .o_next (w_cnt_next)
  );

  // A taken miss evicts whatever lived at that index; a not-taken miss is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
        r_cnt[i]    <= 2'b00;
      end
    end else if (i_resolve_valid) begin
      if (w_rs_hit) begin
        r_cnt[w_rs_idx] <= w_cnt_next;
        if (i_resolve_taken) begin
          r_target[w_rs_idx] <= i_resolve_target;
        end
      end else if (i_resolve_taken) begin
        r_valid[w_rs_idx]  <= 1'b1;
        r_tag[w_rs_idx]    <= w_rs_tag;
        r_target[w_rs_idx] <= i_resolve_target;
        r_cnt[w_rs_idx]    <= INIT_CNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt <= 32'd0;
      r_fail_cnt   <= 32'd0;
    end else begin
      if (i_resolve_valid && (r_branch_cnt != 32'hFFFF_FFFF)) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
      end
      if (w_fail && (r_fail_cnt != 32'hFFFF_FFFF)) begin
        r_fail_cnt <= r_fail_cnt + 32'd1;
      end
    end
  end

  assign o_branch_cnt = r_branch_cnt;
  assign o_fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed scenarios followed by
// random resolves, all compared against a table model held in the bench.
module tb_bht_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pcIf;
  logic [31:0] pcPredict;
  logic [1:0]  binaryPredict;
  logic        bhtHit;
  logic        resolveValid;
  logic [31:0] resolvePc;
  logic        resolveTaken;
  logic [31:0] resolveTarget;
  logic [31:0] pcPredictEx;
  logic        predictFail;
  logic [31:0] redirectPc;
  logic [31:0] branchCnt;
  logic [31:0] failCnt;

  int checks = 0;
  int errors = 0;

  bht_predictor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_pc_if          (pcIf),
    .o_pc_predict     (pcPredict),
    .o_binary_predict (binaryPredict),
    .o_bht_hit        (bhtHit),
    .i_resolve_valid  (resolveValid),
    .i_resolve_pc     (resolvePc),
    .i_resolve_taken  (resolveTaken),
    .i_resolve_target (resolveTarget),
    .i_pc_predict_ex  (pcPredictEx),
    .o_predict_fail   (predictFail),
    .o_redirect_pc    (redirectPc),
    .o_branch_cnt     (branchCnt),
    .o_fail_cnt       (failCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 8 lines, each remembering the word address that owns it.
  typedef struct {
    bit          valid;
    bit [31:0]   wordAddr;
    bit [31:0]   target;
    int          cnt;
  } entry_t;

  entry_t      mTable [8];
  int unsigned mBranches;
  int unsigned mFails;

  function automatic int lineOf(input bit [31:0] pc);
    return int'((pc >> 2) % 8);
  endfunction

  function automatic bit modelHit(input bit [31:0] pc);
    return mTable[lineOf(pc)].valid && (mTable[lineOf(pc)].wordAddr == (pc >> 2));
  endfunction

  function automatic bit [31:0] modelPredict(input bit [31:0] pc);
    if (modelHit(pc) && mTable[lineOf(pc)].cnt >= 2) return mTable[lineOf(pc)].target;
    return pc + 4;
  endfunction

  function automatic bit [31:0] modelActual();
    return resolveTaken ? resolveTarget : resolvePc + 4;
  endfunction

  function automatic bit modelFail();
    return resolveValid && (pcPredictEx != modelActual());
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mTable[i] = '{1'b0, 32'd0, 32'd0, 0};
    mBranches = 0;
    mFails    = 0;
  endtask

  task automatic modelUpdate(input bit fail);
    int l;
    l = lineOf(resolvePc);
    if (!resolveValid) return;
    if (mBranches != 32'hFFFF_FFFF) mBranches++;
    if (fail && mFails != 32'hFFFF_FFFF) mFails++;
    if (modelHit(resolvePc)) begin
      if (resolveTaken) begin
        mTable[l].cnt    = (mTable[l].cnt + 1 > 3) ? 3 : mTable[l].cnt + 1;
        mTable[l].target = resolveTarget;
      end else begin
        mTable[l].cnt = (mTable[l].cnt - 1 < 0) ? 0 : mTable[l].cnt - 1;
      end
    end else if (resolveTaken) begin
      mTable[l] = '{1'b1, resolvePc >> 2, resolveTarget, 2};
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("bht_hit", {31'd0, bhtHit}, {31'd0, modelHit(pcIf)});
    checkOutput("binary_predict", {30'd0, binaryPredict},
                modelHit(pcIf) ? mTable[lineOf(pcIf)].cnt : 0);
    checkOutput("pc_predict", pcPredict, modelPredict(pcIf));
    checkOutput("predict_fail", {31'd0, predictFail}, {31'd0, modelFail()});
    checkOutput("redirect_pc", redirectPc, resolveValid ? modelActual() : 32'd0);
    checkOutput("branch_cnt", branchCnt, mBranches);
    checkOutput("fail_cnt", failCnt, mFails);
  endtask

  // Drives one cycle's inputs away from the edge and checks combinational outputs.
  task automatic applyStimulus(input logic [31:0] pc, input logic rv, input logic [31:0] rpc,
                               input logic tk, input logic [31:0] tgt, input logic [31:0] pex);
    @(negedge clk);
    pcIf          = pc;
    resolveValid  = rv;
    resolvePc     = rpc;
    resolveTaken  = tk;
    resolveTarget = tgt;
    pcPredictEx   = pex;
    #1;
    checkAll();
  endtask

  task automatic tick();
    bit fail;
    fail = modelFail();
    @(posedge clk);
    modelUpdate(fail);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] tgt;
    logic [31:0] pex;
    logic        tk;
    int          sel;

    rst_n = 1'b0;
    pcIf = 32'h40; resolveValid = 0; resolvePc = 0; resolveTaken = 0;
    resolveTarget = 0; pcPredictEx = 0;
    modelReset();
    #12;
    checkOutput("reset_hit", {31'd0, bhtHit}, 32'd0);
    checkOutput("reset_pc_predict", pcPredict, 32'h44);
    checkOutput("reset_binary", {30'd0, binaryPredict}, 32'd0);
    checkOutput("reset_branch_cnt", branchCnt, 32'd0);
    checkOutput("reset_fail_cnt", failCnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'h40, 1, 32'h40, 1, 32'h100, 32'h44);
    checkOutput("alloc_fail", {31'd0, predictFail}, 32'd1);
    checkOutput("alloc_redirect", redirectPc, 32'h100);
    tick();
    applyStimulus(32'h40, 0, 32'h0, 0, 32'h0, 32'h0);
    checkOutput("alloc_hit", {31'd0, bhtHit}, 32'd1);
    checkOutput("alloc_binary", {30'd0, binaryPredict}, 32'd2);
    checkOutput("alloc_predict", pcPredict, 32'h100);
    checkOutput("alloc_branch_cnt", branchCnt, 32'd1);
    checkOutput("alloc_fail_cnt", failCnt, 32'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h40, 1, 32'h40, 1, 32'h100, 32'h100);
      checkOutput("taken_fail", {31'd0, predictFail}, 32'd0);
      tick();
    end
    applyStimulus(32'h40, 0, 32'h0, 0, 32'h0, 32'h0);
    checkOutput("sat_binary", {30'd0, binaryPredict}, 32'd3);

    applyStimulus(32'h40, 1, 32'h40, 0, 32'h100, 32'h100);
    checkOutput("nt1_fail", {31'd0, predictFail}, 32'd1);
    checkOutput("nt1_redirect", redirectPc, 32'h44);
    tick();
    applyStimulus(32'h40, 1, 32'h40, 0, 32'h100, 32'h44);
    checkOutput("nt2_fail", {31'd0, predictFail}, 32'd0);
    checkOutput("nt2_binary", {30'd0, binaryPredict}, 32'd2);
    tick();
    applyStimulus(32'h40, 0, 32'h0, 0, 32'h0, 32'h0);
    checkOutput("nt_binary", {30'd0, binaryPredict}, 32'd1);
    checkOutput("nt_predict", pcPredict, 32'h44);

    applyStimulus(32'h40, 1, 32'h60, 1, 32'h200, 32'h64);
    tick();
    applyStimulus(32'h40, 0, 32'h0, 0, 32'h0, 32'h0);
    checkOutput("alias_old_hit", {31'd0, bhtHit}, 32'd0);
    applyStimulus(32'h60, 0, 32'h0, 0, 32'h0, 32'h0);
    checkOutput("alias_new_hit", {31'd0, bhtHit}, 32'd1);
    checkOutput("alias_new_predict", pcPredict, 32'h200);
    checkOutput("alias_new_binary", {30'd0, binaryPredict}, 32'd2);

    applyStimulus(32'h80, 1, 32'h80, 1, 32'h300, 32'h84);
    checkOutput("hazard_hit", {31'd0, bhtHit}, 32'd0);
    checkOutput("hazard_predict", pcPredict, 32'h84);
    tick();
    applyStimulus(32'h80, 0, 32'h0, 0, 32'h0, 32'h0);
    checkOutput("hazard_after_hit", {31'd0, bhtHit}, 32'd1);

    applyStimulus(32'h80, 0, 32'h1234, 1, 32'hABC, 32'h0);
    checkOutput("bubble_fail", {31'd0, predictFail}, 32'd0);
    checkOutput("bubble_redirect", redirectPc, 32'd0);
    tick();

    for (int n = 0; n < 400; n++) begin
      rpc = 32'h400 | (32'($urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 7)) << 2);
      tgt = $urandom & 32'hFFFF_FFFC;
      tk  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      pex = (sel == 0) ? rpc + 4 : (sel == 1) ? tgt :
            (sel == 2) ? modelPredict(rpc) : ($urandom & 32'hFFFF_FFFC);
      applyStimulus(32'h400 | (32'($urandom_range(0, 2)) << 5) | (32'($urandom_range(0, 7)) << 2),
                    1'($urandom_range(0, 4) != 0), rpc, tk, tgt, pex);
      tick();
    end

    applyStimulus(32'h80, 0, 32'h0, 0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_hit", {31'd0, bhtHit}, 32'd0);
    checkOutput("midreset_predict", pcPredict, 32'h84);
    checkOutput("midreset_branch_cnt", branchCnt, 32'd0);
    checkOutput("midreset_fail_cnt", failCnt, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 20; n++) begin
      rpc = 32'h40 | (32'($urandom_range(0, 7)) << 2);
      applyStimulus(rpc, 1, rpc, 1'($urandom_range(0, 1)), 32'h800, rpc + 4);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
